// File: rtl/maxpool_2x2_conv_2_pkg.sv
// Shared definitions for the 2x2 max-pool engine behind the conv2 result memory.
// Holds map geometry, data/address widths and the FSM state encoding.
// Geometry defaults describe a 26x26 map pooled down to 13x13.
package maxpool_2x2_conv_2_pkg;

  localparam int N_C = 26;          // input columns (even)
  localparam int N_R = 26;          // input rows (even)
  localparam int P_C = N_C / 2;     // pooled columns
  localparam int P_R = N_R / 2;     // pooled rows
  localparam int AWR = 10;          // input memory address width
  localparam int DW  = 8;           // pixel width, two's complement
  localparam int AWP = 8;           // pooled memory address width

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD   = 3'd1;
  localparam state_t S_LAST = 3'd2;
  localparam state_t S_WR   = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // Counter width for a dimension of n entries (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_2x2_conv_2_if.sv
// Bus between the pooling engine and its environment (control, source read port,
// pooled-map write port). master = pooling engine, slave = memories/controller.
// Ports: start/busy/done control, ren/radd/rdata read port, wen/wadd/wdata write port.
interface maxpool_2x2_conv_2_if
  import maxpool_2x2_conv_2_pkg::*;
#(
  parameter int awr = AWR,
  parameter int dw  = DW,
  parameter int awp = AWP
);

  logic           start;
  logic           busy;
  logic           done;
  logic           ren;
  logic [awr-1:0] radd;
  logic [dw-1:0]  rdata;
  logic           wen;
  logic [awp-1:0] wadd;
  logic [dw-1:0]  wdata;

  modport master (
    input  start, rdata,
    output busy, done, ren, radd, wen, wadd, wdata
  );

  modport slave (
    output start, rdata,
    input  busy, done, ren, radd, wen, wadd, wdata
  );

endinterface

// File: rtl/maxpool_2x2_conv_2_pool_window_addr_gen.sv
// Window/pixel counters for the pooling scan; produces the next read address, the
// current window's write address and the last-window / last-pixel flags.
// Ports: k_inc steps the pixel index, win_adv moves to the next window (row-major).
module pool_window_addr_gen
  import maxpool_2x2_conv_2_pkg::*;
#(
  parameter int n_c = N_C,
  parameter int n_r = N_R,
  parameter int awr = AWR,
  parameter int awp = AWP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           k_inc,
  input  logic           win_adv,
  output logic [1:0]     k,
  output logic [awr-1:0] radd_nxt,
  output logic [awp-1:0] wadd_nxt,
  output logic           last_win,
  output logic           last_pix
);

  localparam int PC_W = cnt_width(n_c / 2);
  localparam int PR_W = cnt_width(n_r / 2);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(n_c / 2 - 1);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(n_r / 2 - 1);

  logic [PC_W-1:0] pc;
  logic [PR_W-1:0] pr;
  int              row;
  int              col;

  // k is the index of the next pixel to be issued; k[1] picks the row
  // inside the window, k[0] the column.
  always_comb begin
    row      = 2 * int'(pr) + int'(k[1]);
    col      = 2 * int'(pc) + int'(k[0]);
    radd_nxt = awr'(row * n_c + col);
    wadd_nxt = awp'(int'(pr) * (n_c / 2) + int'(pc));
  end

  assign last_win = (pr == PR_LAST) && (pc == PC_LAST);
  // Every window starts by issuing pixel 0, so k back at 0 while reading
  // means all four pixels of the window have been issued.
  assign last_pix = (k == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k  <= '0;
      pc <= '0;
      pr <= '0;
    end else begin
      if (k_inc) begin
        k <= k + 2'd1;
      end
      if (win_adv) begin
        if (pc == PC_LAST) begin
          pc <= '0;
          // Wrap the row too after the final window so the next pass starts at 0.
          pr <= (pr == PR_LAST) ? '0 : pr + 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_2x2_conv_2.sv
// 2x2 non-overlapping signed max pool from the conv2 result memory to the pooled map.
// Ports: clk, rst_n (async, active low), bus (master side: start/busy/done, read port
// with 1-cycle latency, write port). Six cycles per window, all outputs registered.
module maxpool_2x2_conv_2
  import maxpool_2x2_conv_2_pkg::*;
#(
  parameter int n_c                  = N_C,
  parameter int n_r                  = N_R,
  parameter int addressWidthRstlConv = AWR,
  parameter int dataWidthRstlConv    = DW,
  parameter int addressWidthPool     = AWP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxpool_2x2_conv_2_if.master bus
);

  state_t                                state;
  logic [1:0]                            k;
  logic [addressWidthRstlConv-1:0]       radd_nxt;
  logic [addressWidthPool-1:0]           wadd_nxt;
  logic                                  last_win;
  logic                                  last_pix;
  logic                                  last_q;
  logic                                  k_inc;
  logic                                  win_adv;
  logic signed [dataWidthRstlConv-1:0]   rdata_s;
  logic signed [dataWidthRstlConv-1:0]   max_q;
  logic signed [dataWidthRstlConv-1:0]   max_nxt;

  assign rdata_s = $signed(bus.rdata);

  // Issue a read when leaving IDLE, while pixels remain in RD, and when
  // WR chains straight into the next window.
  assign k_inc   = ((state == S_IDLE) && bus.start)
                 || ((state == S_RD) && !last_pix)
                 || ((state == S_WR) && !last_q);
  // Counters move on during LAST; the write address is taken on the same edge.
  assign win_adv = (state == S_LAST);

  pool_window_addr_gen #(
    .n_c (n_c),
    .n_r (n_r),
    .awr (addressWidthRstlConv),
    .awp (addressWidthPool)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .k_inc    (k_inc),
    .win_adv  (win_adv),
    .k        (k),
    .radd_nxt (radd_nxt),
    .wadd_nxt (wadd_nxt),
    .last_win (last_win),
    .last_pix (last_pix)
  );

  // rdata lags the address by one cycle. In RD, k==1 is the first read cycle
  // (no data yet) and k==2 carries pixel 0, which loads the max unconditionally.
  always_comb begin
    max_nxt = max_q;
    if ((state == S_RD) && (k == 2'd2)) begin
      max_nxt = rdata_s;
    end else if (((state == S_RD) && (k != 2'd1)) || (state == S_LAST)) begin
      if (rdata_s > max_q) begin
        max_nxt = rdata_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.ren   <= 1'b0;
      bus.radd  <= '0;
      bus.wen   <= 1'b0;
      bus.wadd  <= '0;
      bus.wdata <= '0;
      max_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.wen  <= 1'b0;
      max_q    <= max_nxt;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_RD;
            bus.busy <= 1'b1;
            bus.ren  <= 1'b1;
            bus.radd <= radd_nxt;
          end
        end
        S_RD: begin
          if (last_pix) begin
            state   <= S_LAST;
            bus.ren <= 1'b0;
          end else begin
            bus.radd <= radd_nxt;
          end
        end
        S_LAST: begin
          state     <= S_WR;
          bus.wen   <= 1'b1;
          bus.wadd  <= wadd_nxt;
          bus.wdata <= max_nxt;
          last_q    <= last_win;
        end
        S_WR: begin
          if (last_q) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state    <= S_RD;
            bus.ren  <= 1'b1;
            bus.radd <= radd_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
